// File: rtl/gate_bist_if.sv
// ----------------------------------------------------------------------------
// gate_bist_if
// Control/status bundle of the gate_bist self-test engine.
//
// Handshake: the master raises `start` for one cycle with `op` valid in the
// same cycle; the engine accepts it only when it is not busy (IDLE or DONE).
// `busy` stays high for the whole sweep, `done` rises when the sweep ends and
// stays high (with `pass`/`err_count` valid) until the next accepted start.
//
// Signals:
//   start      master -> slave  sweep request
//   op         master -> slave  expected-function select (latched on start)
//   busy       slave -> master  sweep in progress
//   done       slave -> master  sweep finished, results valid
//   pass       slave -> master  1 iff err_count == 0 (valid with done)
//   err_count  slave -> master  saturating mismatch count
// Optional (GATE_BIST_FAIL_CAPTURE_EN defined):
//   fail_valid, fail_a, fail_b  first failing vector of the sweep
// ----------------------------------------------------------------------------
interface gate_bist_if #(
    parameter int CNT_W = 16
`ifdef GATE_BIST_FAIL_CAPTURE_EN
    , parameter int WIDTH = 2
`endif
);
    logic             start;
    logic [2:0]       op;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
    logic             fail_valid;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;
`endif

    modport master (
        output start, op,
`ifdef GATE_BIST_FAIL_CAPTURE_EN
        input  fail_valid, fail_a, fail_b,
`endif
        input  busy, done, pass, err_count
    );

    modport slave (
        input  start, op,
`ifdef GATE_BIST_FAIL_CAPTURE_EN
        output fail_valid, fail_a, fail_b,
`endif
        output busy, done, pass, err_count
    );
endinterface

// File: rtl/gate_bist.sv
// ----------------------------------------------------------------------------
// gate_bist
// Exhaustive self-test engine for a WIDTH-bit two-input bitwise gate. It
// drives every (a, b) combination onto the gate, compares the gate output
// against the function chosen by `op` and reports a saturating error count.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   ctrl      gate_bist_if.slave: start/op in, busy/done/pass/err_count out
//   a_o, b_o  stimulus to the gate under test
//   y_i       gate output, combinational in a_o/b_o
//   state_o   FSM state (0 IDLE, 1 RUN, 2 DONE) for debug/observation
//
// Optional feature: define GATE_BIST_FAIL_CAPTURE_EN to capture the first
// failing vector of each sweep into ctrl.fail_valid/fail_a/fail_b.
// ----------------------------------------------------------------------------
module gate_bist #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    gate_bist_if.slave       ctrl,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    input  logic [WIDTH-1:0] y_i,
    output logic [1:0]       state_o
);
    localparam int VW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [2:0]       op_q;
    logic [VW-1:0]    vec_q;
    logic [VW-1:0]    vec_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] err_d;
    logic [WIDTH-1:0] exp_y;
    logic             mismatch;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
    logic             fail_valid_q;
    logic [WIDTH-1:0] fail_a_q;
    logic [WIDTH-1:0] fail_b_q;
`endif

    // Expected gate response for the vector currently on a_o/b_o.
    always_comb begin
        exp_y = '0;
        case (op_q)
            3'd0: exp_y = a_q & b_q;
            3'd1: exp_y = a_q | b_q;
            3'd2: exp_y = ~(a_q & b_q);
            3'd3: exp_y = ~(a_q | b_q);
            3'd4: exp_y = a_q ^ b_q;
            3'd5: exp_y = ~(a_q ^ b_q);
            3'd6: exp_y = ~a_q;
            default: exp_y = a_q;
        endcase
    end

    // Case inequality so that X/Z on the gate output counts as a failure.
    assign mismatch = (y_i !== exp_y);

    // Error count after this cycle's compare; sticks at all-ones.
    assign err_d = (mismatch && (err_q != '1)) ? err_q + CNT_W'(1) : err_q;
    assign vec_d = vec_q + VW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            vec_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (ctrl.start) begin
                        state_q <= S_RUN;
                        op_q    <= ctrl.op;
                        vec_q   <= '0;
                        a_q     <= '0;
                        b_q     <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
                        fail_valid_q <= 1'b0;
                        fail_a_q     <= '0;
                        fail_b_q     <= '0;
`endif
                    end
                end
                S_RUN: begin
                    err_q <= err_d;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
                    if (mismatch && !fail_valid_q) begin
                        fail_valid_q <= 1'b1;
                        fail_a_q     <= a_q;
                        fail_b_q     <= b_q;
                    end
`endif
                    // The last vector (all ones) ends the sweep; the counter
                    // never wraps while still in RUN.
                    if (vec_q == '1) begin
                        state_q <= S_DONE;
                        vec_q   <= '0;
                        a_q     <= '0;
                        b_q     <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                    end else begin
                        vec_q <= vec_d;
                        a_q   <= vec_d[WIDTH-1:0];
                        b_q   <= vec_d[VW-1:WIDTH];
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign a_o            = a_q;
    assign b_o            = b_q;
    assign state_o        = state_q;
    assign ctrl.busy      = busy_q;
    assign ctrl.done      = done_q;
    assign ctrl.pass      = pass_q;
    assign ctrl.err_count = err_q;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
    assign ctrl.fail_valid = fail_valid_q;
    assign ctrl.fail_a     = fail_a_q;
    assign ctrl.fail_b     = fail_b_q;
`endif
endmodule
